// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Purpose : Groups the byte hand-off signals between the UART receiver and the
//           bus controller that consumes the received bytes.
// Signals : i_ack        - one-clock pulse from the controller consuming the byte
//           o_data       - last received byte
//           o_valid      - a byte is held and has not been consumed
//           o_frame_err  - stop bit of the held byte was sampled low
//           o_overrun    - sticky, a byte was dropped while o_valid was high
//           o_parity_err - parity mismatch on the held byte
// Modports: master - bus controller side (drives i_ack)
//           slave  - receiver side (drives the byte and status flags)
// -----------------------------------------------------------------------------
interface uart_rx_if;
    logic       i_ack;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_parity_err;

    modport master (
        output i_ack,
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_overrun,
        input  o_parity_err
    );

    modport slave (
        input  i_ack,
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_overrun,
        output o_parity_err
    );
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Purpose : 8-bit UART receiver, LSB first, one start bit, one stop bit and an
//           optional even parity bit. Each bit is sampled once, at its
//           mid-point, by a single bit timer. A completed byte is held
//           for the bus controller until it pulses i_ack.
// Params  : CLKS_PER_BIT - clocks per serial bit (4..65535, even values only)
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous, active-low reset
//           i_rx  - asynchronous serial line, idle high
//           bus   - uart_rx_if.slave: i_ack in; o_data, o_valid, o_frame_err,
//                   o_overrun, o_parity_err out
// Config  : define UART_RX_PARITY_EN to receive and check an even parity bit
//           between the last data bit and the stop bit. Without it the frame
//           is 10 bits and o_parity_err is tied to 0.
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_rx,
    uart_rx_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    logic sync1;
    logic sync2;
    logic sync_prev;

    logic [7:0] data_q;
    logic       valid_q;
    logic       frame_q;
    logic       overrun_q;

`ifdef UART_RX_PARITY_EN
    logic       parity_bit;
    logic       parity_q;
`endif

    // All three flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= i_rx;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // Receive FSM and the held-byte registers. The ack clear is written first
    // so that a byte completing in the same clock overrides it and stays valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit <= 1'b0;
            parity_q   <= 1'b0;
`endif
        end else begin
            if (bus.i_ack && valid_q) begin
                valid_q   <= 1'b0;
                frame_q   <= 1'b0;
                overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_q  <= 1'b0;
`endif
            end

            case (state)
                IDLE: begin
                    // Only a high-to-low transition arms the receiver, so a
                    // line held low (break) cannot retrigger it.
                    if (!sync2 && sync_prev) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        // A start bit that is high again at its mid-point was
                        // a glitch; drop it silently.
                        state   <= sync2 ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shift   <= {sync2, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL_M1) begin
                        cnt        <= '0;
                        parity_bit <= sync2;
                        state      <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    // The byte is delivered at the stop mid-point; the rest of
                    // the stop bit is not waited for.
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (valid_q && !bus.i_ack) begin
                            overrun_q <= 1'b1;
                        end else begin
                            data_q   <= shift;
                            valid_q  <= 1'b1;
                            frame_q  <= ~sync2;
`ifdef UART_RX_PARITY_EN
                            parity_q <= parity_bit ^ (^shift);
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_frame_err = frame_q;
    assign bus.o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err = parity_q;
`else
    assign bus.o_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clocks per serial bit (legal range 4..65535, even values only).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port i_ack  input  1  one-clock pulse from the bus controller consuming the held byte.
REQ-006 SHALL have port o_data  output  8  last received byte, LSB first on the line.
REQ-007 SHALL have port o_valid  output  1  level, byte held and unconsumed.
REQ-008 SHALL have port o_frame_err  output  1  stop bit of the held byte sampled low.
REQ-009 SHALL have port o_overrun  output  1  sticky, a byte was dropped because o_valid was high.
REQ-010 SHALL have port o_parity_err  output  1  parity mismatch on the held byte (tied 0 when parity is compiled out).

Function
REQ-011 SHALL pass i_rx through a two-flop synchronizer (reset value 1) and detect start as synchronized low with previous synchronized high (edge cycle E).
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; a single bit-timer counter of width clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-013 SHALL sample the synchronized line at E + CLKS_PER_BIT/2 + k*CLKS_PER_BIT: k=0 start, k=1..8 data bits 0..7, then parity (if compiled in), then stop.
REQ-014 SHALL return START to IDLE without any output change if the start sample is high (glitch rejection).
REQ-015 SHALL arm IDLE only on a falling edge, so a line held low (break) never retriggers.
REQ-016 SHALL, one clock after the stop sample, load o_data, o_frame_err (= NOT stop sample), o_parity_err, set o_valid, and enter IDLE; stop is not awaited past its mid-point.
REQ-017 SHALL clear o_valid, o_frame_err, o_parity_err, o_overrun on the clock after i_ack is high; i_ack with o_valid low is ignored.
REQ-018 SHALL, when a byte completes while o_valid is high and i_ack is low, discard the new byte, keep o_data unchanged, and set o_overrun.
REQ-019 SHALL, when a byte completes in the same clock as i_ack, load the new byte, keep o_valid high, and leave o_overrun clear.
REQ-020 SHALL give total latency, i_rx falling edge to o_valid high, of 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks (no parity), plus CLKS_PER_BIT with parity.

Reset
REQ-021 SHALL on reset low force IDLE, counters 0, synchronizer flops 1, o_data 0x00, and o_valid, o_frame_err, o_parity_err, o_overrun 0, regardless of frame in progress.
REQ-022 SHALL after reset release receive the next complete frame correctly, ignoring any partial frame.

Configuration
REQ-023 SHALL, with macro UART_RX_PARITY_EN defined, insert PARITY state checking even parity over 8 data bits and drive o_parity_err; without it, skip PARITY, frame is 10 bits, o_parity_err constant 0.

Verification (CLKS_PER_BIT=16)
REQ-024 SHALL cover: frame 0xA5, stop 1, no parity -> o_valid high exactly 155 clocks after i_rx falls, o_data=0xA5, error flags 0.
REQ-025 SHALL cover: i_rx low for 3 clocks then high -> no o_valid, FSM back in IDLE, next 0x3C frame received correctly.
REQ-026 SHALL cover: frame 0x81 with stop bit 0 and line held low afterwards -> o_data=0x81, o_frame_err=1, no second byte.
REQ-027 SHALL cover: frames 0x11 then 0x22 without i_ack -> o_data=0x11, o_overrun=1; i_ack -> all flags and o_valid 0 next clock.
REQ-028 SHALL cover: reset asserted at data bit 4 of 0x55 -> outputs zero immediately; subsequent 0xF0 frame -> o_data=0xF0.
REQ-029 SHALL cover with UART_RX_PARITY_EN: 0x07 with parity bit 0 -> o_parity_err=1, valid at 171 clocks; parity bit 1 -> o_parity_err=0.
